// File: rtl/number_scanner_pkg.sv
// Shared constants for the UART number scanner and its printer counterpart:
// baud timing, ASCII codes used by the parser, and the receiver state type.
package number_scanner_pkg;

    // 125 MHz / 115200 baud
    localparam int CLKS_PER_BIT_DEFAULT = 1085;

    localparam logic [7:0] ASCII_0  = 8'h30;
    localparam logic [7:0] ASCII_9  = 8'h39;
    localparam logic [7:0] ASCII_CR = 8'h0D;
    localparam logic [7:0] ASCII_LF = 8'h0A;
    localparam logic [7:0] ASCII_SP = 8'h20;

    typedef enum logic [1:0] {
        RX_IDLE  = 2'd0,
        RX_START = 2'd1,
        RX_DATA  = 2'd2,
        RX_STOP  = 2'd3
    } rx_state_t;

endpackage

// File: rtl/number_scanner_uart_rx.sv
// 8N1 UART receiver: two-flop synchroniser followed by a mid-bit sampling
// state machine. Produces one byte_valid pulse per good frame and one
// frame_err pulse when the stop bit reads low.
module number_scanner_uart_rx
    import number_scanner_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       rx_in,
    output logic [7:0] data,
    output logic       byte_valid,
    output logic       frame_err
);

    localparam int CNT_W = $clog2(CLKS_PER_BIT + 1);
    localparam logic [CNT_W-1:0] FULL_LAST = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);

    logic             rx_meta;
    logic             rx_sync;
    rx_state_t        state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift_reg;
    logic             wait_idle;

    // Bring the asynchronous line into the clock domain; preset to idle-high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
        end else begin
            rx_meta <= rx_in;
            rx_sync <= rx_meta;
        end
    end

    // Frame receiver; after a bad stop bit it holds off until the line idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= RX_IDLE;
            clk_cnt    <= '0;
            bit_idx    <= '0;
            shift_reg  <= '0;
            data       <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            wait_idle  <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
            case (state)
                RX_IDLE: begin
                    if (!rx_sync) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        state   <= RX_START;
                    end
                end
                RX_START: begin
                    if (clk_cnt == HALF_LAST) begin
                        clk_cnt <= '0;
                        state   <= rx_sync ? RX_IDLE : RX_DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_DATA: begin
                    if (clk_cnt == FULL_LAST) begin
                        clk_cnt   <= '0;
                        shift_reg <= {rx_sync, shift_reg[7:1]};
                        bit_idx   <= bit_idx + 3'd1;
                        if (bit_idx == 3'd7) begin
                            state <= RX_STOP;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                RX_STOP: begin
                    if (wait_idle) begin
                        if (rx_sync) begin
                            wait_idle <= 1'b0;
                            state     <= RX_IDLE;
                        end
                    end else if (clk_cnt == FULL_LAST) begin
                        clk_cnt <= '0;
                        if (rx_sync) begin
                            data       <= shift_reg;
                            byte_valid <= 1'b1;
                            state      <= RX_IDLE;
                        end else begin
                            frame_err <= 1'b1;
                            wait_idle <= 1'b1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: state <= RX_IDLE;
            endcase
        end
    end

endmodule

// File: rtl/number_scanner.sv
// Number scanner: receives ASCII over UART and parses unsigned decimal
// numbers into WIDTH-bit values, strobing each completed number once.
// Values that do not fit are wrapped and flagged through overflow.
module number_scanner
    import number_scanner_pkg::*;
#(
    parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEFAULT,
    parameter int WIDTH        = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             rx_in,
    output logic [WIDTH-1:0] value,
    output logic             value_valid,
    output logic             overflow,
    output logic             err
);

    logic [7:0]       rx_data;
    logic             byte_valid;
    logic             frame_err;
    logic [WIDTH-1:0] acc;
    logic             ovf_acc;
    logic             digit_seen;
    logic             is_digit;
    logic             is_term;
    logic [WIDTH+3:0] acc_next_full;

    number_scanner_uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_uart_rx (
        .clk       (clk),
        .rst       (rst),
        .rx_in     (rx_in),
        .data      (rx_data),
        .byte_valid(byte_valid),
        .frame_err (frame_err)
    );

    // Classify the received byte and form acc*10+digit with headroom for overflow detection.
    always_comb begin
        is_digit      = (rx_data >= ASCII_0) && (rx_data <= ASCII_9);
        is_term       = (rx_data == ASCII_CR) || (rx_data == ASCII_LF) || (rx_data == ASCII_SP);
        acc_next_full = ((WIDTH+4)'(acc) << 3) + ((WIDTH+4)'(acc) << 1) + (WIDTH+4)'(rx_data[3:0]);
    end

    // Parser: accumulate digits, publish on a terminator, flag bad bytes and frames.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            acc         <= '0;
            ovf_acc     <= 1'b0;
            digit_seen  <= 1'b0;
            value       <= '0;
            overflow    <= 1'b0;
            value_valid <= 1'b0;
            err         <= 1'b0;
        end else begin
            value_valid <= 1'b0;
            err         <= 1'b0;
            if (frame_err) begin
                err        <= 1'b1;
                acc        <= '0;
                ovf_acc    <= 1'b0;
                digit_seen <= 1'b0;
            end else if (byte_valid) begin
                if (is_digit) begin
                    acc        <= acc_next_full[WIDTH-1:0];
                    digit_seen <= 1'b1;
                    if (|acc_next_full[WIDTH+3:WIDTH]) begin
                        ovf_acc <= 1'b1;
                    end
                end else if (is_term) begin
                    if (digit_seen) begin
                        value       <= acc;
                        overflow    <= ovf_acc;
                        value_valid <= 1'b1;
                        acc         <= '0;
                        ovf_acc     <= 1'b0;
                        digit_seen  <= 1'b0;
                    end
                end else begin
                    err        <= 1'b1;
                    acc        <= '0;
                    ovf_acc    <= 1'b0;
                    digit_seen <= 1'b0;
                end
            end
        end
    end

endmodule

// File: tb/tb_number_scanner.sv
// Testbench for number_scanner: drives 8N1 frames on rx_in and compares
// every value_valid / err pulse against an event list built from the
// decimal parsing rules applied to the characters sent.
`timescale 1ns/1ps
module tb_number_scanner;

    localparam int CPB = 20;
    localparam int W   = 16;

    logic         clk = 1'b0;
    logic         rst;
    logic         rx_in;
    logic [W-1:0] value;
    logic         value_valid;
    logic         overflow;
    logic         err;

    typedef struct {
        bit          is_err;
        logic [15:0] val;
        bit          ovf;
    } ev_t;

    ev_t         exp_q[$];
    ev_t         mon_e;
    longint      model_num  = 0;
    bit          model_seen = 0;
    logic [15:0] last_val   = '0;
    logic        last_ovf   = 1'b0;
    int          checks = 0;
    int          errors = 0;
    int          events_expected = 0;
    int          events_seen     = 0;
    int          ev_before;

    number_scanner #(
        .CLKS_PER_BIT(CPB),
        .WIDTH       (W)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_in      (rx_in),
        .value      (value),
        .value_valid(value_valid),
        .overflow   (overflow),
        .err        (err)
    );

    // Free-running 100 MHz clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        checks++;
        assert (observed === expected) else begin
            errors++;
            $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, observed, expected);
        end
    endtask

    // Reference: what a host expects from one received character.
    function automatic void modelByte(input logic [7:0] b, input bit stop_ok);
        ev_t e;
        if (stop_ok && b >= 8'h30 && b <= 8'h39) begin
            model_num  = model_num * 10 + longint'(b - 8'h30);
            model_seen = 1;
        end else if (stop_ok && (b == 8'h0D || b == 8'h0A || b == 8'h20)) begin
            if (model_seen) begin
                e.is_err = 0;
                e.val    = 16'(model_num % 65536);
                e.ovf    = (model_num > 65535);
                last_val = e.val;
                last_ovf = e.ovf;
                exp_q.push_back(e);
                events_expected++;
            end
            model_num  = 0;
            model_seen = 0;
        end else begin
            e.is_err = 1;
            e.val    = '0;
            e.ovf    = 0;
            exp_q.push_back(e);
            events_expected++;
            model_num  = 0;
            model_seen = 0;
        end
    endfunction

    task automatic applyStimulus(input logic [7:0] b, input bit stop_bit);
        modelByte(b, stop_bit);
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 8; i++) begin
            rx_in = b[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = stop_bit;
        repeat (CPB) @(negedge clk);
        rx_in = 1'b1;
        if (!stop_bit) repeat (CPB) @(negedge clk);
    endtask

    task automatic sendString(input string tag, input string s);
        for (int i = 0; i < s.len(); i++) applyStimulus(s[i], 1'b1);
        repeat (4) @(negedge clk);
        checkOutput({tag, "_pending"}, exp_q.size(), 0);
        checkOutput({tag, "_value_hold"}, {16'h0, value}, {16'h0, last_val});
        checkOutput({tag, "_ovf_hold"}, {31'h0, overflow}, {31'h0, last_ovf});
    endtask

    // Monitor: every pulse must match the next expected event in order.
    always @(negedge clk) begin
        if (!rst && (value_valid || err)) begin
            events_seen++;
            checkOutput("valid_err_exclusive", {31'h0, value_valid & err}, 32'h0);
            if (exp_q.size() == 0) begin
                checkOutput("unexpected_pulse", {30'h0, value_valid, err}, 32'h0);
            end else begin
                mon_e = exp_q.pop_front();
                checkOutput("pulse_is_err", {31'h0, err}, {31'h0, mon_e.is_err});
                checkOutput("pulse_is_valid", {31'h0, value_valid}, {31'h0, !mon_e.is_err});
                if (!mon_e.is_err) begin
                    checkOutput("value", {16'h0, value}, {16'h0, mon_e.val});
                    checkOutput("overflow", {31'h0, overflow}, {31'h0, mon_e.ovf});
                end
            end
        end
    end

    initial begin
        logic [7:0] nine;
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (5) @(negedge clk);
        checkOutput("reset_value", {16'h0, value}, 32'h0);
        checkOutput("reset_valid", {31'h0, value_valid}, 32'h0);
        checkOutput("reset_overflow", {31'h0, overflow}, 32'h0);
        checkOutput("reset_err", {31'h0, err}, 32'h0);
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);

        $display("[TB] directed sequences");
        sendString("ten", "10\r");
        sendString("max", "65535 ");
        sendString("wrap", "65536\n");
        sendString("bare_term", "\r\n");
        sendString("thirty", "30\r\n");
        sendString("illegal", "1a2\r");
        sendString("zeros", "007 ");

        applyStimulus(8'h35, 1'b0);
        sendString("frame_err", "7\r");

        $display("[TB] glitch shorter than half a bit");
        ev_before = events_seen;
        rx_in = 1'b0;
        repeat (CPB / 4) @(negedge clk);
        rx_in = 1'b1;
        repeat (3 * CPB) @(negedge clk);
        checkOutput("glitch_no_pulse", events_seen, ev_before);
        sendString("after_glitch", "12\r");

        $display("[TB] reset during bit 3 of a frame");
        nine  = 8'h39;
        rx_in = 1'b0;
        repeat (CPB) @(negedge clk);
        for (int i = 0; i < 3; i++) begin
            rx_in = nine[i];
            repeat (CPB) @(negedge clk);
        end
        rx_in = nine[3];
        repeat (CPB / 2) @(negedge clk);
        rst   = 1'b1;
        rx_in = 1'b1;
        repeat (3) @(negedge clk);
        checkOutput("midreset_value", {16'h0, value}, 32'h0);
        checkOutput("midreset_overflow", {31'h0, overflow}, 32'h0);
        checkOutput("midreset_valid", {31'h0, value_valid}, 32'h0);
        checkOutput("midreset_err", {31'h0, err}, 32'h0);
        events_expected -= exp_q.size();
        exp_q.delete();
        model_num  = 0;
        model_seen = 0;
        last_val   = '0;
        last_ovf   = 1'b0;
        rst = 1'b0;
        repeat (2 * CPB) @(negedge clk);
        sendString("after_reset", "4\r");

        $display("[TB] randomized numbers");
        for (int n = 0; n < 25; n++) begin
            int ndig;
            int pick;
            ndig = int'($urandom_range(1, 6));
            for (int d = 0; d < ndig; d++) begin
                pick = int'($urandom_range(0, 15));
                if (pick == 0)
                    applyStimulus(8'h41 + 8'($urandom_range(0, 25)), 1'b1);
                else if (pick == 1)
                    applyStimulus(8'h30 + 8'($urandom_range(0, 9)), 1'b0);
                else
                    applyStimulus(8'h30 + 8'($urandom_range(0, 9)), 1'b1);
            end
            pick = int'($urandom_range(0, 2));
            applyStimulus(pick == 0 ? 8'h0D : (pick == 1 ? 8'h0A : 8'h20), 1'b1);
            if ($urandom_range(0, 3) == 0) applyStimulus(8'h20, 1'b1);
            repeat (4) @(negedge clk);
            checkOutput("random_pending", exp_q.size(), 0);
        end

        checkOutput("events_total", events_seen, events_expected);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
